dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter TUNE_WIDTH, default 16: tuning-word width; matches the DDS tuning input.
REQ-002 SHALL have parameter STEP_CNT_WIDTH, default 12: width of the step counter and step index.
REQ-003 SHALL have parameter DWELL_WIDTH, default 16: width of the dwell-length counter.
REQ-004 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-005 SHALL have port n_RST  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-007 SHALL have port abort  input  1  terminate the sweep in progress.
REQ-008 SHALL have port cfg_start_word  input  TUNE_WIDTH  first tuning word.
REQ-009 SHALL have port cfg_step  input  TUNE_WIDTH  unsigned increment per step.
REQ-010 SHALL have port cfg_dir  input  1  0 = sweep up, 1 = sweep down.
REQ-011 SHALL have port cfg_num_steps  input  STEP_CNT_WIDTH  steps after the first word.
REQ-012 SHALL have port cfg_dwell  input  DWELL_WIDTH  cycles per word; 0 is treated as 1.
REQ-013 SHALL have port tuning_word  output  TUNE_WIDTH  registered word to the DDS.
REQ-014 SHALL have port dds_rst_n  output  1  registered, active-low phase-accumulator clear to the DDS.
REQ-015 SHALL have port busy  output  1  high in PRIME and DWELL.
REQ-016 SHALL have port done  output  1  one-cycle pulse on normal completion.
REQ-017 SHALL have port step_idx  output  STEP_CNT_WIDTH  index of the word currently output.
REQ-018 SHALL have port sat  output  1  sticky per sweep; set when a step clamps.

Function
REQ-019 SHALL implement the FSM states IDLE, PRIME, DWELL and DONE.
REQ-020 SHALL, in IDLE with start=1, latch all cfg_* inputs and enter PRIME; cfg_* SHALL be ignored at every other time.
REQ-021 SHALL, in PRIME (one cycle), drive dds_rst_n=0, load tuning_word=cfg_start_word, and clear step_idx and sat, then enter DWELL.
REQ-022 SHALL hold each word in DWELL for max(cfg_dwell,1) cycles, counted from the first DWELL cycle.
REQ-023 SHALL, at the end of a dwell with step_idx<num_steps, update tuning_word and increment step_idx on the same edge and remain in DWELL.
REQ-024 SHALL, at the end of a dwell with step_idx==num_steps, enter DONE; DONE SHALL assert done for one cycle and then return to IDLE.
REQ-025 SHALL compute an up step as tuning_word+step saturated at all-ones, and a down step as tuning_word-step saturated at zero; any clamp SHALL set sat.
REQ-026 SHALL, with num_steps=0, output cfg_start_word for one dwell and then enter DONE.
REQ-027 SHALL ignore start while busy or in DONE; no queuing.
REQ-028 SHALL, on abort in PRIME or DWELL, enter IDLE next cycle, hold tuning_word, and suppress done; abort SHALL have priority over a coincident dwell end.
REQ-029 SHALL ignore abort in IDLE and DONE.
REQ-030 SHALL hold tuning_word, step_idx and sat in IDLE until the next PRIME.

Reset
REQ-031 SHALL, while n_RST=0, immediately force: state=IDLE, tuning_word=0, dds_rst_n=0, busy=0, done=0, step_idx=0, sat=0, counters=0.
REQ-032 SHALL drive dds_rst_n=1 from the first clk edge after n_RST deasserts, except during PRIME.
REQ-033 SHALL, on reset mid-sweep, abandon the sweep with no done pulse.

Structure
REQ-034 SHALL place the state enum type and the default widths in the shared package dds_pkg.
REQ-035 SHALL implement the dwell count in the sub-module dds_dwell_timer: load, count down, and a one-cycle expire output.

Verification
REQ-036 SHALL verify an up sweep: start_word=0x1000, step=0x0100, num_steps=3, dwell=4 -> 1 PRIME cycle with dds_rst_n=0, then 0x1000/0x1100/0x1200/0x1300 for 4 cycles each, then done for 1 cycle, sat=0.
REQ-037 SHALL verify up saturation: 0xFF00, step=0x0080, num_steps=3, dwell=1 -> 0xFF00, 0xFF80, 0xFFFF, 0xFFFF; sat=1 from the third word.
REQ-038 SHALL verify a degenerate sweep: num_steps=0, dwell=0 -> start_word for 1 cycle, done on the next cycle, busy high for 2 cycles.
REQ-039 SHALL verify abort: abort during the 2nd cycle of word 0x1100 -> IDLE next cycle, tuning_word held at 0x1100, done never asserted, a fresh start is accepted.
REQ-040 SHALL verify start while busy: start pulsed mid-sweep with different cfg -> no effect on the sequence or its timing.
REQ-041 SHALL verify reset: n_RST low mid-dwell -> all outputs zero asynchronously, no done pulse, and the next sweep starts cleanly.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS frequency-sweep controller.
package dds_pkg;

  localparam int DEF_TUNE_WIDTH     = 16;
  localparam int DEF_STEP_CNT_WIDTH = 12;
  localparam int DEF_DWELL_WIDTH    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_DWELL = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell timer: loads a cycle count, counts down to zero, and flags the last cycle of the dwell.
module dds_dwell_timer
  import dds_pkg::*;
#(
  parameter int WIDTH = DEF_DWELL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] count_q;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  // A loaded value of N expires on the N-th cycle after the load edge.
  assign expire_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller: primes the DDS, then steps the tuning word with saturation,
// holding each word for a programmable dwell.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int TUNE_WIDTH     = DEF_TUNE_WIDTH,
  parameter int STEP_CNT_WIDTH = DEF_STEP_CNT_WIDTH,
  parameter int DWELL_WIDTH    = DEF_DWELL_WIDTH
) (
  input  logic                      clk,
  input  logic                      n_RST,
  input  logic                      start,
  input  logic                      abort,
  input  logic [TUNE_WIDTH-1:0]     cfg_start_word,
  input  logic [TUNE_WIDTH-1:0]     cfg_step,
  input  logic                      cfg_dir,
  input  logic [STEP_CNT_WIDTH-1:0] cfg_num_steps,
  input  logic [DWELL_WIDTH-1:0]    cfg_dwell,
  output logic [TUNE_WIDTH-1:0]     tuning_word,
  output logic                      dds_rst_n,
  output logic                      busy,
  output logic                      done,
  output logic [STEP_CNT_WIDTH-1:0] step_idx,
  output logic                      sat
);

  sweep_state_e              state_q;
  logic [TUNE_WIDTH-1:0]     step_q;
  logic                      dir_q;
  logic [STEP_CNT_WIDTH-1:0] num_steps_q;
  logic [DWELL_WIDTH-1:0]    dwell_len_q;
  logic [TUNE_WIDTH-1:0]     tuning_word_q;
  logic [STEP_CNT_WIDTH-1:0] step_idx_q;
  logic                      sat_q, busy_q, done_q, dds_rst_n_q;

  logic [TUNE_WIDTH:0]       up_sum;
  logic [TUNE_WIDTH-1:0]     next_word;
  logic                      clamp;
  logic                      more_steps, dwell_expire, advance, timer_load;
  logic [DWELL_WIDTH-1:0]    timer_val;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    up_sum    = {1'b0, tuning_word_q} + {1'b0, step_q};
    next_word = '0;
    clamp     = 1'b0;
    if (!dir_q) begin
      clamp     = up_sum[TUNE_WIDTH];
      next_word = clamp ? '1 : up_sum[TUNE_WIDTH-1:0];
    end else begin
      clamp     = (step_q > tuning_word_q);
      next_word = clamp ? '0 : tuning_word_q - step_q;
    end
  end

  assign more_steps = (step_idx_q < num_steps_q);
  // Reload the dwell on the first DWELL entry and on every step; park the timer at zero otherwise.
  assign advance    = !abort && ((state_q == ST_PRIME) ||
                                 (state_q == ST_DWELL && dwell_expire && more_steps));
  assign timer_load = (state_q == ST_PRIME) ||
                      (state_q == ST_DWELL && (abort || dwell_expire));
  assign timer_val  = advance ? dwell_len_q : '0;

  dds_dwell_timer #(.WIDTH(DWELL_WIDTH)) u_dwell_timer (
    .clk        (clk),
    .rst_n      (n_RST),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .expire_o   (dwell_expire)
  );

  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      state_q       <= ST_IDLE;
      step_q        <= '0;
      dir_q         <= 1'b0;
      num_steps_q   <= '0;
      dwell_len_q   <= '0;
      tuning_word_q <= '0;
      step_idx_q    <= '0;
      sat_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      dds_rst_n_q   <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      dds_rst_n_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q       <= ST_PRIME;
            step_q        <= cfg_step;
            dir_q         <= cfg_dir;
            num_steps_q   <= cfg_num_steps;
            dwell_len_q   <= (cfg_dwell == '0) ? DWELL_WIDTH'(1) : cfg_dwell;
            tuning_word_q <= cfg_start_word;
            step_idx_q    <= '0;
            sat_q         <= 1'b0;
            busy_q        <= 1'b1;
            dds_rst_n_q   <= 1'b0;
          end
        end
        ST_PRIME: begin
          state_q <= abort ? ST_IDLE : ST_DWELL;
          busy_q  <= !abort;
        end
        ST_DWELL: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (dwell_expire) begin
            if (more_steps) begin
              tuning_word_q <= next_word;
              step_idx_q    <= step_idx_q + STEP_CNT_WIDTH'(1);
              if (clamp) sat_q <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tuning_word = tuning_word_q;
  assign dds_rst_n   = dds_rst_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign step_idx    = step_idx_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: per-cycle comparison against a sweep-trace model,
// directed scenarios pinned with literal values, then randomized traffic.
module tb_dds_sweep_ctrl;

  localparam int TW = 16;
  localparam int SW = 12;
  localparam int DW = 16;

  logic          clk, n_RST, start, abort, cfg_dir;
  logic [TW-1:0] cfg_start_word, cfg_step;
  logic [SW-1:0] cfg_num_steps;
  logic [DW-1:0] cfg_dwell;
  logic [TW-1:0] tuning_word;
  logic          dds_rst_n, busy, done, sat;
  logic [SW-1:0] step_idx;

  dds_sweep_ctrl #(.TUNE_WIDTH(TW), .STEP_CNT_WIDTH(SW), .DWELL_WIDTH(DW)) dut (
    .clk            (clk),
    .n_RST          (n_RST),
    .start          (start),
    .abort          (abort),
    .cfg_start_word (cfg_start_word),
    .cfg_step       (cfg_step),
    .cfg_dir        (cfg_dir),
    .cfg_num_steps  (cfg_num_steps),
    .cfg_dwell      (cfg_dwell),
    .tuning_word    (tuning_word),
    .dds_rst_n      (dds_rst_n),
    .busy           (busy),
    .done           (done),
    .step_idx       (step_idx),
    .sat            (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [TW-1:0] tw;
    logic [SW-1:0] idx;
    logic          busy;
    logic          done;
    logic          sat;
    logic          drn;
  } rec_t;

  // ---------------- behavioural model: expected output trace, one record per cycle
  rec_t exp_q[$];
  rec_t cur = '{default: 0};

  task automatic gen_sweep(input logic [TW-1:0] sw, input logic [TW-1:0] st, input logic dir,
                           input logic [SW-1:0] n, input logic [DW-1:0] dw);
    int     d;
    longint w, stv;
    logic   s;
    d   = (dw == 0) ? 1 : int'(dw);
    w   = longint'(sw);
    stv = longint'(st);
    s   = 1'b0;
    exp_q.push_back('{tw: sw, idx: '0, busy: 1'b1, done: 1'b0, sat: 1'b0, drn: 1'b0});
    for (int k = 0; k <= int'(n); k++) begin
      if (k > 0) begin
        if (!dir) w = w + stv;
        else      w = w - stv;
        if (w > 65535) begin w = 65535; s = 1'b1; end
        if (w < 0)     begin w = 0;     s = 1'b1; end
      end
      repeat (d) exp_q.push_back('{tw: TW'(w), idx: SW'(k), busy: 1'b1, done: 1'b0, sat: s, drn: 1'b1});
    end
    exp_q.push_back('{tw: TW'(w), idx: n, busy: 1'b0, done: 1'b1, sat: s, drn: 1'b1});
  endtask

  always @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      exp_q.delete();
      cur = '{default: 0};
    end else if (cur.busy && abort) begin
      exp_q.delete();
      cur.busy = 1'b0; cur.done = 1'b0; cur.drn = 1'b1;
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else if (!cur.busy && !cur.done && start) begin
      gen_sweep(cfg_start_word, cfg_step, cfg_dir, cfg_num_steps, cfg_dwell);
      cur = exp_q.pop_front();
    end else begin
      cur.busy = 1'b0; cur.done = 1'b0; cur.drn = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("cyc_tuning_word", tuning_word, cur.tw);
    check("cyc_step_idx",    step_idx,    cur.idx);
    check("cyc_busy",        busy,        cur.busy);
    check("cyc_done",        done,        cur.done);
    check("cyc_sat",         sat,         cur.sat);
    check("cyc_dds_rst_n",   dds_rst_n,   cur.drn);
  end

  // ---------------- observation log for literal checks
  logic log_en = 1'b0;
  rec_t log_q[$];
  always @(negedge clk) begin
    if (log_en)
      log_q.push_back('{tw: tuning_word, idx: step_idx, busy: busy, done: done, sat: sat, drn: dds_rst_n});
  end

  int            prime_cnt, busy_cnt, done_cnt, prime_pos, done_pos;
  logic [TW-1:0] run_w[$];
  logic [SW-1:0] run_idx[$];
  int            run_len[$];
  logic          run_sat[$];

  task automatic analyze();
    logic prev_dwell;
    prime_cnt = 0; busy_cnt = 0; done_cnt = 0; prime_pos = -1; done_pos = -1;
    run_w.delete(); run_idx.delete(); run_len.delete(); run_sat.delete();
    prev_dwell = 1'b0;
    foreach (log_q[i]) begin
      if (log_q[i].busy) busy_cnt++;
      if (log_q[i].done) begin done_cnt++; if (done_pos < 0) done_pos = i; end
      if (log_q[i].busy && !log_q[i].drn) begin prime_cnt++; if (prime_pos < 0) prime_pos = i; end
      if (log_q[i].busy && log_q[i].drn) begin
        if (prev_dwell && run_idx[$] == log_q[i].idx) run_len[$]++;
        else begin
          run_w.push_back(log_q[i].tw); run_idx.push_back(log_q[i].idx);
          run_len.push_back(1); run_sat.push_back(log_q[i].sat);
        end
        prev_dwell = 1'b1;
      end else prev_dwell = 1'b0;
    end
  endtask

  task automatic check_run(input string tag, input int k, input logic [TW-1:0] ew, input int elen,
                           input logic esat);
    check({tag, "_word"}, run_w[k], ew);
    check({tag, "_len"},  run_len[k], elen);
    check({tag, "_sat"},  run_sat[k], esat);
  endtask

  task automatic do_start(input logic [TW-1:0] sw, input logic [TW-1:0] st, input logic dir,
                          input logic [SW-1:0] n, input logic [DW-1:0] dw);
    @(negedge clk);
    cfg_start_word = sw; cfg_step = st; cfg_dir = dir; cfg_num_steps = n; cfg_dwell = dw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_start_word = TW'($urandom); cfg_step = TW'($urandom); cfg_dir = 1'($urandom);
    cfg_num_steps = SW'($urandom); cfg_dwell = DW'($urandom);
  endtask

  task automatic log_begin();
    @(negedge clk);
    log_q.delete();
    log_en = 1'b1;
  endtask

  task automatic log_end(input int cycles);
    repeat (cycles) @(negedge clk);
    log_en = 1'b0;
    analyze();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    n_RST = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_start_word = '0; cfg_step = '0; cfg_dir = 1'b0; cfg_num_steps = '0; cfg_dwell = '0;
    #12;
    check("rst_tuning_word", tuning_word, 0);
    check("rst_dds_rst_n", dds_rst_n, 0);
    check("rst_busy", busy, 0);
    check("rst_step_idx", step_idx, 0);
    #10 n_RST = 1'b1;

    // Up sweep, four words of four cycles.
    log_begin();
    do_start(16'h1000, 16'h0100, 1'b0, 12'd3, 16'd4);
    log_end(24);
    check("up_prime_cycles", prime_cnt, 1);
    check("up_runs", run_w.size(), 4);
    check_run("up_w0", 0, 16'h1000, 4, 1'b0);
    check_run("up_w1", 1, 16'h1100, 4, 1'b0);
    check_run("up_w2", 2, 16'h1200, 4, 1'b0);
    check_run("up_w3", 3, 16'h1300, 4, 1'b0);
    check("up_done_cnt", done_cnt, 1);
    check("up_done_pos", done_pos - prime_pos, 17);
    check("up_busy_cycles", busy_cnt, 17);

    // Up saturation with dwell 1.
    log_begin();
    do_start(16'hFF00, 16'h0080, 1'b0, 12'd3, 16'd1);
    log_end(10);
    check("sat_runs", run_w.size(), 4);
    check_run("sat_w0", 0, 16'hFF00, 1, 1'b0);
    check_run("sat_w1", 1, 16'hFF80, 1, 1'b0);
    check_run("sat_w2", 2, 16'hFFFF, 1, 1'b1);
    check_run("sat_w3", 3, 16'hFFFF, 1, 1'b1);
    check("sat_done_cnt", done_cnt, 1);

    // Degenerate sweep: no steps, zero dwell.
    log_begin();
    do_start(16'hABCD, 16'h0010, 1'b0, 12'd0, 16'd0);
    log_end(6);
    check("deg_busy_cycles", busy_cnt, 2);
    check("deg_runs", run_w.size(), 1);
    check_run("deg_w0", 0, 16'hABCD, 1, 1'b0);
    check("deg_done_pos", done_pos - prime_pos, 2);
    check("deg_done_cnt", done_cnt, 1);

    // Abort during the second cycle of word 0x1100.
    do_start(16'h1000, 16'h0100, 1'b0, 12'd3, 16'd4);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (tuning_word == 16'h1100) found = 1'b1;
    end
    check("abort_reach_1100", found, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_word_held", tuning_word, 16'h1100);
    check("abort_idx_held", step_idx, 1);
    log_begin();
    log_end(30);
    check("abort_no_done", done_cnt, 0);
    check("abort_stays_idle", busy_cnt, 0);
    log_begin();
    do_start(16'h0100, 16'h0080, 1'b1, 12'd3, 16'd2);
    log_end(14);
    check("down_runs", run_w.size(), 4);
    check_run("down_w0", 0, 16'h0100, 2, 1'b0);
    check_run("down_w1", 1, 16'h0080, 2, 1'b0);
    check_run("down_w2", 2, 16'h0000, 2, 1'b0);
    check_run("down_w3", 3, 16'h0000, 2, 1'b1);
    check("down_done_cnt", done_cnt, 1);

    // Start pulsed mid-sweep with different configuration.
    log_begin();
    do_start(16'h2000, 16'h0010, 1'b0, 12'd2, 16'd3);
    repeat (3) @(negedge clk);
    do_start(16'h9000, 16'h1000, 1'b1, 12'd7, 16'd1);
    log_end(20);
    check("busy_start_runs", run_w.size(), 3);
    check_run("busy_start_w0", 0, 16'h2000, 3, 1'b0);
    check_run("busy_start_w1", 1, 16'h2010, 3, 1'b0);
    check_run("busy_start_w2", 2, 16'h2020, 3, 1'b0);
    check("busy_start_busy_cycles", busy_cnt, 10);
    check("busy_start_done_pos", done_pos - prime_pos, 10);

    // Asynchronous reset mid-dwell.
    do_start(16'h3000, 16'h0001, 1'b0, 12'd5, 16'd4);
    repeat (6) @(negedge clk);
    #2 n_RST = 1'b0;
    #1;
    check("mid_rst_tuning_word", tuning_word, 0);
    check("mid_rst_dds_rst_n", dds_rst_n, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_step_idx", step_idx, 0);
    check("mid_rst_sat", sat, 0);
    @(negedge clk);
    #2 n_RST = 1'b1;
    log_begin();
    log_end(10);
    check("post_rst_no_done", done_cnt, 0);
    check("post_rst_idle", busy_cnt, 0);
    log_begin();
    do_start(16'h1000, 16'h0100, 1'b0, 12'd3, 16'd4);
    log_end(24);
    check("post_rst_runs", run_w.size(), 4);
    check_run("post_rst_w3", 3, 16'h1300, 4, 1'b0);
    check("post_rst_done_cnt", done_cnt, 1);

    // Randomized traffic, checked every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 30) == 0);
      cfg_start_word = TW'($urandom);
      cfg_step = ($urandom_range(0, 3) == 0) ? TW'($urandom) : TW'($urandom_range(0, 255));
      cfg_dir = 1'($urandom);
      cfg_num_steps = SW'($urandom_range(0, 5));
      cfg_dwell = DW'($urandom_range(0, 3));
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
